fifo_wide2narrow: RTL

//  Parametrised width-down-converting FIFO. Buffers IN_W-bit words (e.g. AES 128-bit blocks)
//  and emits them as IN_W/OUT_W narrow chunks over a valid/ready stream (e.g. 32-bit CPU/bus side).
//  Has full backpressure on both sides, configurable chunk order and per-chunk byte swap,
//  and an occupancy count. Sits between the AES core output and the 32-bit readback path.

---
 rtl/fifo_wide2narrow.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_wide2narrow.sv
// Width-down-converting FIFO: stores IN_W-bit words and streams each one out as
// IN_W/OUT_W chunks through a holding register. Chunk order and per-chunk byte swap are selectable.
module fifo_wide2narrow #(
   parameter int IN_W      = 128,
   parameter int OUT_W     = 32,
   parameter int DEPTH     = 16,
   parameter bit BYTE_SWAP = 1'b1,
   parameter bit MSW_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [IN_W-1:0]          in_data_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [OUT_W-1:0]         out_data_o,
   output logic                     out_last_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int N  = IN_W / OUT_W;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   logic [IN_W-1:0]  mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [IN_W-1:0]  hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic [CW-1:0]    idx_q, idx_d;

   logic             store_empty;
   logic             do_write;
   logic             do_accept;
   logic             do_reload;
   logic [CW-1:0]    sel;
   logic [OUT_W-1:0] chunk;

   // The MSB of each pointer counts laps, so equal low bits with differing MSBs means full.
   assign store_empty = (wr_ptr_q == rd_ptr_q);
   assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o     = wr_ptr_q - rd_ptr_q;
   assign in_ready_o  = !full_o;
   assign empty_o     = store_empty && !hold_vld_q;

   assign out_valid_o = hold_vld_q;
   assign out_last_o  = hold_vld_q && (idx_q == LAST_IDX);

   assign do_write  = in_valid_i && in_ready_o;
   assign do_accept = hold_vld_q && out_ready_i;
   assign do_reload = !store_empty && (!hold_vld_q || (do_accept && out_last_o));

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      idx_d      = idx_q;
      if (do_write) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_reload) begin
         hold_d     = mem_q[rd_ptr_q[AW-1:0]];
         hold_vld_d = 1'b1;
         idx_d      = '0;
         rd_ptr_d   = rd_ptr_q + 1'b1;
      end else if (do_accept) begin
         if (out_last_o) begin
            hold_vld_d = 1'b0;
            idx_d      = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         hold_vld_q <= 1'b0;
         idx_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hold_vld_q <= hold_vld_d;
         idx_q      <= idx_d;
      end
   end

   // NOTE: storage and the holding data path carry no reset; validity is tracked by the
   // pointers and hold_vld_q, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
      if (do_write) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
      end
   end

   always_comb begin
      sel   = MSW_FIRST ? (LAST_IDX - idx_q) : idx_q;
      chunk = hold_q[int'(sel)*OUT_W +: OUT_W];
   end

   generate
      if (BYTE_SWAP) begin : g_swap
         for (genvar b = 0; b < OUT_W/8; b++) begin : g_byte
            assign out_data_o[b*8 +: 8] = chunk[(OUT_W/8-1-b)*8 +: 8];
         end
      end else begin : g_pass
         assign out_data_o = chunk;
      end
   endgenerate

endmodule
